// File: rtl/hermes_input_buffer.sv
// -----------------------------------------------------------------------------
// hermes_input_buffer
// Per-port input buffer of the Hermes router. Flits arriving from the upstream
// link are queued in a circular FIFO. When a packet header reaches the FIFO head,
// a routing request goes to the switch control. After the grant, the buffer
// streams header, size and payload flits to the crossbar, with sending_o high
// for the whole packet.
//
// Ports:
//   clk_i     in   clock, rising edge
//   rst_ni    in   asynchronous active-low reset
//   rx_i      in   upstream flit valid
//   data_i    in   upstream flit
//   credit_o  out  FIFO not full (upstream may send)
//   req_o     out  routing request to switch control
//   ack_i     in   routing grant, one-cycle pulse
//   sending_o out  packet transmission in progress
//   tx_o      out  flit valid toward crossbar
//   data_o    out  FIFO head flit (header target in [15:0] while req_o high)
//   credit_i  in   downstream space available
// -----------------------------------------------------------------------------
module hermes_input_buffer #(
    parameter int unsigned FLIT_SIZE   = 32,
    parameter int unsigned BUFFER_SIZE = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rx_i,
    input  logic [FLIT_SIZE-1:0] data_i,
    output logic                 credit_o,
    output logic                 req_o,
    input  logic                 ack_i,
    output logic                 sending_o,
    output logic                 tx_o,
    output logic [FLIT_SIZE-1:0] data_o,
    input  logic                 credit_i
);

    localparam int unsigned PTR_W = $clog2(BUFFER_SIZE);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_HEADER  = 3'd2,
        S_SIZE    = 3'd3,
        S_PAYLOAD = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [FLIT_SIZE-1:0] r_mem [BUFFER_SIZE];
    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [CNT_W-1:0]     r_count;
    logic [FLIT_SIZE-1:0] r_flits;
    logic                 w_wr;
    logic                 w_rd;
    logic                 w_empty;
    logic                 w_full;

    // FIFO status and handshakes
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CNT_W'(BUFFER_SIZE));
    assign credit_o = !w_full;
    assign w_wr     = rx_i && !w_full;
    assign w_rd     = tx_o && credit_i;
    assign data_o   = r_mem[r_head];

    // Flit storage; a write while full is dropped by w_wr
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < BUFFER_SIZE; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr) begin
            r_mem[r_tail] <= data_i;
        end
    end

    // Pointers wrap naturally because BUFFER_SIZE is a power of two
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_rd) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Remaining payload flits: loaded from the size flit, decremented per transfer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_flits <= '0;
        end else if (w_rd) begin
            if (r_state == S_SIZE) begin
                r_flits <= data_o;
            end else if (r_state == S_PAYLOAD) begin
                r_flits <= r_flits - FLIT_SIZE'(1);
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_next_state = S_REQ;
                end
            end
            S_REQ: begin
                if (ack_i) begin
                    w_next_state = S_HEADER;
                end
            end
            S_HEADER: begin
                if (w_rd) begin
                    w_next_state = S_SIZE;
                end
            end
            S_SIZE: begin
                if (w_rd) begin
                    w_next_state = (data_o != '0) ? S_PAYLOAD : S_IDLE;
                end
            end
            S_PAYLOAD: begin
                if (w_rd && (r_flits == FLIT_SIZE'(1))) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output decode from registered state; req_o and tx_o are mutually exclusive
    always_comb begin
        req_o     = 1'b0;
        sending_o = 1'b0;
        tx_o      = 1'b0;
        case (r_state)
            S_REQ: begin
                req_o = 1'b1;
            end
            S_HEADER, S_SIZE, S_PAYLOAD: begin
                sending_o = 1'b1;
                tx_o      = !w_empty;
            end
            default: begin
                req_o     = 1'b0;
                sending_o = 1'b0;
                tx_o      = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_hermes_input_buffer.sv
// -----------------------------------------------------------------------------
// tb_hermes_input_buffer
// Directed self-checking bench for hermes_input_buffer (FLIT_SIZE=32,
// BUFFER_SIZE=8). Inputs change and outputs are sampled 1 ns after the
// rising edge.
// -----------------------------------------------------------------------------
module tb_hermes_input_buffer;

    logic        clk_i;
    logic        rst_ni;
    logic        rx_i;
    logic [31:0] data_i;
    logic        credit_o;
    logic        req_o;
    logic        ack_i;
    logic        sending_o;
    logic        tx_o;
    logic [31:0] data_o;
    logic        credit_i;

    int n_checks = 0;
    int n_pass   = 0;

    hermes_input_buffer #(
        .FLIT_SIZE   (32),
        .BUFFER_SIZE (8)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .rx_i      (rx_i),
        .data_i    (data_i),
        .credit_o  (credit_o),
        .req_o     (req_o),
        .ack_i     (ack_i),
        .sending_o (sending_o),
        .tx_o      (tx_o),
        .data_o    (data_o),
        .credit_i  (credit_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni   = 1'b0;
        rx_i     = 1'b0;
        data_i   = '0;
        ack_i    = 1'b0;
        credit_i = 1'b0;
        #12;
        n_checks++;
        if ({credit_o, req_o, tx_o, sending_o} !== 4'b1000) begin
            $display("FAIL reset_ctrl: credit/req/tx/sending=%b required 1000",
                     {credit_o, req_o, tx_o, sending_o});
        end else n_pass++;
        n_checks++;
        if (data_o !== 32'h0) begin
            $display("FAIL reset_data: data_o=%h required 00000000", data_o);
        end else n_pass++;
        @(posedge clk_i);
        #3;
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_basic_packet();
        logic [31:0] exp_q [5];
        exp_q = '{32'h0000_0102, 32'h3, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
        credit_i = 1'b1;
        rx_i = 1'b1; data_i = exp_q[0];
        tick();
        n_checks++;
        if (req_o !== 1'b0) begin
            $display("FAIL basic_req_early: req_o=%b required 0", req_o);
        end else n_pass++;
        data_i = exp_q[1];
        tick();
        n_checks++;
        if (req_o !== 1'b1 || data_o[15:0] !== 16'h0102) begin
            $display("FAIL basic_req_rise: req_o=%b target=%h required 1/0102",
                     req_o, data_o[15:0]);
        end else n_pass++;
        data_i = exp_q[2];
        tick();
        data_i = exp_q[3];
        tick();
        data_i = exp_q[4];
        ack_i  = 1'b1;
        tick();
        rx_i  = 1'b0;
        ack_i = 1'b0;
        n_checks++;
        if (req_o !== 1'b0 || sending_o !== 1'b1) begin
            $display("FAIL basic_grant: req_o=%b sending_o=%b required 0/1", req_o, sending_o);
        end else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (tx_o !== 1'b1 || data_o !== exp_q[i] || sending_o !== 1'b1) begin
                $display("FAIL basic_xfer%0d: tx=%b sending=%b data=%h required 1/1/%h",
                         i, tx_o, sending_o, data_o, exp_q[i]);
            end else n_pass++;
            tick();
        end
        n_checks++;
        if (sending_o !== 1'b0 || tx_o !== 1'b0 || req_o !== 1'b0) begin
            $display("FAIL basic_release: sending/tx/req=%b%b%b required 000",
                     sending_o, tx_o, req_o);
        end else n_pass++;
    endtask

    task automatic test_full_fifo();
        logic [31:0] flits [10];
        flits = '{32'h0000_0200, 32'h6, 32'hD2, 32'hD3, 32'hD4, 32'hD5, 32'hD6, 32'hD7,
                  32'hEE08, 32'hEE09};
        credit_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rx_i = 1'b1; data_i = flits[i];
            n_checks++;
            if (credit_o !== (i < 8)) begin
                $display("FAIL full_credit%0d: credit_o=%b required %b", i, credit_o, (i < 8));
            end else n_pass++;
            tick();
        end
        rx_i = 1'b0;
        n_checks++;
        if (credit_o !== 1'b0 || req_o !== 1'b1 || data_o !== flits[0]) begin
            $display("FAIL full_hold: credit=%b req=%b data=%h required 0/1/%h",
                     credit_o, req_o, data_o, flits[0]);
        end else n_pass++;
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        tick();
        n_checks++;
        if (sending_o !== 1'b1 || tx_o !== 1'b1 || data_o !== flits[0] || credit_o !== 1'b0) begin
            $display("FAIL full_stall: sending=%b tx=%b data=%h credit=%b required 1/1/%h/0",
                     sending_o, tx_o, data_o, credit_o, flits[0]);
        end else n_pass++;
        credit_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (tx_o !== 1'b1 || data_o !== flits[i]) begin
                $display("FAIL full_drain%0d: tx=%b data=%h required 1/%h", i, tx_o, data_o, flits[i]);
            end else n_pass++;
            tick();
            if (i == 0) begin
                n_checks++;
                if (credit_o !== 1'b1) begin
                    $display("FAIL full_credit_back: credit_o=%b required 1", credit_o);
                end else n_pass++;
            end
        end
        n_checks++;
        if (credit_o !== 1'b1 || tx_o !== 1'b0 || sending_o !== 1'b0) begin
            $display("FAIL full_end: credit/tx/sending=%b%b%b required 100",
                     credit_o, tx_o, sending_o);
        end else n_pass++;
        tick();
        n_checks++;
        if (req_o !== 1'b0) begin
            $display("FAIL full_dropped: req_o=%b required 0", req_o);
        end else n_pass++;
    endtask

    task automatic test_size_zero();
        logic [31:0] flits [4];
        flits = '{32'h0000_0301, 32'h0, 32'h0000_0405, 32'h0};
        credit_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rx_i = 1'b1; data_i = flits[i];
            tick();
        end
        rx_i = 1'b0;
        n_checks++;
        if (req_o !== 1'b1 || data_o !== flits[0]) begin
            $display("FAIL zero_req1: req=%b data=%h required 1/%h", req_o, data_o, flits[0]);
        end else n_pass++;
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (tx_o !== 1'b1 || sending_o !== 1'b1 || data_o !== flits[i]) begin
                $display("FAIL zero_xfer%0d: tx=%b sending=%b data=%h required 1/1/%h",
                         i, tx_o, sending_o, data_o, flits[i]);
            end else n_pass++;
            tick();
        end
        n_checks++;
        if (sending_o !== 1'b0 || tx_o !== 1'b0 || req_o !== 1'b0) begin
            $display("FAIL zero_idle: sending/tx/req=%b%b%b required 000", sending_o, tx_o, req_o);
        end else n_pass++;
        tick();
        n_checks++;
        if (req_o !== 1'b1 || data_o !== flits[2]) begin
            $display("FAIL zero_req2: req=%b data=%h required 1/%h", req_o, data_o, flits[2]);
        end else n_pass++;
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        tick();
        tick();
        n_checks++;
        if (sending_o !== 1'b0 || credit_o !== 1'b1 || tx_o !== 1'b0) begin
            $display("FAIL zero_end: sending/credit/tx=%b%b%b required 010", sending_o, credit_o, tx_o);
        end else n_pass++;
    endtask

    task automatic test_credit_toggle();
        logic [31:0] flits [6];
        logic [31:0] got [$];
        int brk;
        int last_x;
        flits = '{32'h0000_0506, 32'h4, 32'h5A00_0000, 32'h5A00_0001, 32'h5A00_0002, 32'h5A00_0003};
        credit_i = 1'b0;
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        tick();
        n_checks++;
        if (req_o !== 1'b0 || sending_o !== 1'b0) begin
            $display("FAIL toggle_idle_ack: req=%b sending=%b required 0/0", req_o, sending_o);
        end else n_pass++;
        rx_i = 1'b1; data_i = flits[0];
        tick();
        data_i = flits[1];
        tick();
        rx_i = 1'b0;
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        brk = -1;
        last_x = -2;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (sending_o === 1'b0) begin
                brk = cyc;
                break;
            end
            credit_i = cyc[0];
            rx_i   = (cyc < 4);
            data_i = (cyc < 4) ? flits[cyc + 2] : 32'h0;
            ack_i  = (cyc == 2 || cyc == 5);
            if (tx_o === 1'b1 && credit_i === 1'b1) begin
                got.push_back(data_o);
                last_x = cyc;
            end
            tick();
        end
        rx_i = 1'b0;
        ack_i = 1'b0;
        n_checks++;
        if (brk < 0 || brk != last_x + 1) begin
            $display("FAIL toggle_release: sending fell at cycle %0d required %0d", brk, last_x + 1);
        end else n_pass++;
        n_checks++;
        if (got.size() != 6) begin
            $display("FAIL toggle_count: transfers=%0d required 6", got.size());
        end else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== flits[i]) begin
                $display("FAIL toggle_order%0d: data=%h required %h", i,
                         (i < got.size()) ? got[i] : 32'hx, flits[i]);
            end else n_pass++;
        end
        credit_i = 1'b1;
        tick();
        n_checks++;
        if (req_o !== 1'b0 || tx_o !== 1'b0 || credit_o !== 1'b1) begin
            $display("FAIL toggle_end: req/tx/credit=%b%b%b required 001", req_o, tx_o, credit_o);
        end else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] flits [4];
        flits = '{32'h0000_0607, 32'h5, 32'h6000_0000, 32'h6000_0001};
        credit_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rx_i = 1'b1; data_i = flits[i];
            tick();
        end
        rx_i = 1'b0;
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        tick();
        tick();
        tick();
        n_checks++;
        if (sending_o !== 1'b1 || tx_o !== 1'b1 || data_o !== flits[3]) begin
            $display("FAIL rstmid_pre: sending=%b tx=%b data=%h required 1/1/%h",
                     sending_o, tx_o, data_o, flits[3]);
        end else n_pass++;
        #3;
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if ({credit_o, req_o, tx_o, sending_o} !== 4'b1000 || data_o !== 32'h0) begin
            $display("FAIL rstmid_async: credit/req/tx/sending=%b data=%h required 1000/00000000",
                     {credit_o, req_o, tx_o, sending_o}, data_o);
        end else n_pass++;
        @(posedge clk_i);
        #3;
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (req_o !== 1'b0 || tx_o !== 1'b0 || sending_o !== 1'b0) begin
                $display("FAIL rstmid_quiet%0d: req/tx/sending=%b%b%b required 000",
                         i, req_o, tx_o, sending_o);
            end else n_pass++;
        end
        rx_i = 1'b1; data_i = 32'h0000_0708;
        tick();
        rx_i = 1'b0;
        n_checks++;
        if (req_o !== 1'b0) begin
            $display("FAIL rstmid_req_early: req_o=%b required 0", req_o);
        end else n_pass++;
        tick();
        n_checks++;
        if (req_o !== 1'b1 || data_o !== 32'h0000_0708) begin
            $display("FAIL rstmid_req: req=%b data=%h required 1/00000708", req_o, data_o);
        end else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_packet();
        test_full_fifo();
        test_size_zero();
        test_credit_toggle();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
